// File: rtl/mem_ctrl_pkg.sv
// Shared constants, op codes, state encoding and small helpers for the memory sweep controller.
package mem_ctrl_pkg;

    localparam int unsigned SIZE    = 5;
    localparam int unsigned MEMSIZE = 25;

    typedef enum logic [1:0] {
        OP_COPY = 2'b00,
        OP_INV  = 2'b01,
        OP_CLR  = 2'b10,
        OP_SET  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_WRITE,
        S_DONE
    } state_e;

    // Cell i lives at line bit MEMSIZE-1-i.
    function automatic logic [SIZE-1:0] bit_pos(input logic [SIZE-1:0] idx);
        return SIZE'(MEMSIZE - 1) - idx;
    endfunction

    // New cell value for a modifying op, given the value just read.
    function automatic logic write_val(input op_e op, input logic cur);
        logic v;
        unique case (op)
            OP_INV:  v = ~cur;
            OP_CLR:  v = 1'b0;
            OP_SET:  v = 1'b1;
            default: v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/sweep_counter.sv
// Index counter for the sweep: synchronous clear, saturating increment, last-cell flag.
module sweep_counter
    import mem_ctrl_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [SIZE-1:0] cnt_o,
    output logic            last_o
);

    logic [SIZE-1:0] cnt_q, cnt_d;

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == SIZE'(MEMSIZE - 1));

    // Next count: clear wins, increment never passes the last cell.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !last_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_sweep_ctrl.sv
// Sequencer that loads a 25-cell bit memory and sweeps it, snapshotting each cell and
// optionally rewriting it (invert/clear/set). Defining PARITY_EN adds a parity_o output
// carrying the XOR of the snapshot, updated as the sweep finishes.
module mem_sweep_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [MEMSIZE-1:0] line_in_i,
    input  logic               abort_i,
    output logic               ready_o,
    output logic               done_o,
    output logic               aborted_o,
    output logic [MEMSIZE-1:0] snapshot_o,
    output logic               mem_init_o,
    output logic [MEMSIZE-1:0] mem_line_o,
    output logic [SIZE-1:0]    mem_index_o,
    output logic               mem_val_o,
    output logic               mem_write_o,
    output logic               mem_read_o,
    input  logic               mem_out_i
`ifdef PARITY_EN
    ,
    output logic               parity_o
`endif
);

    state_e             state_q;
    op_e                op_q;
    logic [MEMSIZE-1:0] line_q, snapshot_q, snap_upd;
    logic               done_q, aborted_q, init_q, read_q, write_q, val_q;
    logic [SIZE-1:0]    cnt;
    logic               cnt_last, cnt_clr, cnt_inc;
    logic               accept, sweeping, step_end, go_done;
`ifdef PARITY_EN
    logic               parity_q;
    assign parity_o = parity_q;
`endif

    sweep_counter u_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .cnt_o  (cnt),
        .last_o (cnt_last)
    );

    // Sweep decisions: a step ends after READ for COPY, otherwise after WRITE.
    always_comb begin
        accept   = (state_q == S_IDLE) && start_i;
        sweeping = (state_q == S_LOAD) || (state_q == S_READ) || (state_q == S_WRITE);
        step_end = (state_q == S_WRITE) || ((state_q == S_READ) && (op_q == OP_COPY));
        go_done  = sweeping && (abort_i || (step_end && cnt_last));
        cnt_clr  = accept || (state_q == S_LOAD);
        cnt_inc  = step_end && !go_done;
        snap_upd = snapshot_q;
        if (state_q == S_READ) begin
            snap_upd[bit_pos(cnt)] = mem_out_i;
        end
    end

    // Control FSM; all outputs are registered and strobes default low every cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            op_q       <= OP_COPY;
            line_q     <= '0;
            snapshot_q <= '0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            init_q     <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            val_q      <= 1'b0;
`ifdef PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            init_q    <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            val_q     <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q       <= op_e'(op_i);
                        line_q     <= line_in_i;
                        snapshot_q <= '0;
                        init_q     <= 1'b1;
                        state_q    <= S_LOAD;
`ifdef PARITY_EN
                        parity_q   <= 1'b0;
`endif
                    end
                end
                S_LOAD, S_READ, S_WRITE: begin
                    if (state_q == S_READ) begin
                        snapshot_q <= snap_upd;
                    end
                    if (go_done) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        aborted_q <= abort_i;
`ifdef PARITY_EN
                        parity_q  <= ^snap_upd;
`endif
                    end else if ((state_q == S_READ) && (op_q != OP_COPY)) begin
                        state_q <= S_WRITE;
                        write_q <= 1'b1;
                        // mem_out_i is the value being snapshotted this cycle.
                        val_q   <= write_val(op_q, mem_out_i);
                    end else begin
                        state_q <= S_READ;
                        read_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o     = (state_q == S_IDLE);
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;
    assign snapshot_o  = snapshot_q;
    assign mem_init_o  = init_q;
    assign mem_line_o  = line_q;
    assign mem_index_o = cnt;
    assign mem_val_o   = val_q;
    assign mem_write_o = write_q;
    assign mem_read_o  = read_q;

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Self-checking bench for mem_sweep_ctrl with a behavioural bit-memory attached.
module tb_mem_sweep_ctrl;

    localparam int MS = 25;
    localparam logic [1:0] C_COPY = 2'b00;
    localparam logic [1:0] C_INV  = 2'b01;
    localparam logic [1:0] C_CLR  = 2'b10;
    localparam logic [1:0] C_SET  = 2'b11;

    logic        clk, rst_n, start, abort, ready, done, aborted;
    logic        mem_init, mem_val, mem_write, mem_read, mem_out;
    logic [1:0]  op;
    logic [24:0] line_in, snapshot, mem_line, mem_q;
    logic [4:0]  mem_index;
`ifdef PARITY_EN
    logic        parity;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int n_read, n_write, n_init, n_excl;

    typedef struct {
        logic [1:0]  op;
        logic [24:0] line;
        logic [24:0] exp_snap;
        logic [24:0] exp_mem;
        logic        exp_par;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    mem_sweep_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .op_i        (op),
        .line_in_i   (line_in),
        .abort_i     (abort),
        .ready_o     (ready),
        .done_o      (done),
        .aborted_o   (aborted),
        .snapshot_o  (snapshot),
        .mem_init_o  (mem_init),
        .mem_line_o  (mem_line),
        .mem_index_o (mem_index),
        .mem_val_o   (mem_val),
        .mem_write_o (mem_write),
        .mem_read_o  (mem_read),
        .mem_out_i   (mem_out)
`ifdef PARITY_EN
        ,
        .parity_o    (parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory block: init loads the line, write updates one cell, read is combinational.
    always @(posedge clk) begin
        if (mem_init) mem_q <= mem_line;
        else if (mem_write) mem_q[24 - int'(mem_index)] <= mem_val;
    end
    assign mem_out = mem_q[24 - int'(mem_index)];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic cell_op(input logic [1:0] o, input logic c);
        case (o)
            C_COPY:  return c;
            C_INV:   return ~c;
            C_CLR:   return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // Memory after the first n_mod cells have been processed.
    function automatic logic [24:0] model_mem(input logic [1:0] o, input logic [24:0] line,
                                              input int n_mod);
        logic [24:0] r;
        r = line;
        for (int i = 0; i < MS; i++) begin
            if (i < n_mod) r[MS-1-i] = cell_op(o, line[MS-1-i]);
        end
        return r;
    endfunction

    function automatic int model_lat(input logic [1:0] o);
        return (o == C_COPY) ? 1 + MS + 1 : 1 + 2 * MS + 1;
    endfunction

    // Called just after an accept edge; counts cycles until done (bounded).
    task automatic wait_done(input int bound, output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        n_read = 0;
        n_write = 0;
        n_init = 0;
        n_excl = 0;
        while (cyc < bound && !got) begin
            @(negedge clk);
            cyc++;
            n_read += int'(mem_read);
            n_write += int'(mem_write);
            n_init += int'(mem_init);
            if (int'(mem_read) + int'(mem_write) + int'(mem_init) > 1) n_excl++;
            if (done) got = 1'b1;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag, input bit with_abort);
        int cyc;
        bit got;
        @(negedge clk);
        start = 1'b1;
        abort = with_abort;
        op = v.op;
        line_in = v.line;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        op = 2'($urandom);
        line_in = 25'($urandom);
        wait_done(200, cyc, got);
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_lat"}, cyc, v.exp_lat);
        check({tag, "_snap"}, snapshot, v.exp_snap);
        check({tag, "_aborted"}, aborted, 0);
        check({tag, "_mem"}, mem_q, v.exp_mem);
        check({tag, "_reads"}, n_read, MS);
        check({tag, "_writes"}, n_write, (v.op == C_COPY) ? 0 : MS);
        check({tag, "_inits"}, n_init, 1);
        check({tag, "_excl"}, n_excl, 0);
`ifdef PARITY_EN
        check({tag, "_parity"}, parity, v.exp_par);
`endif
        @(negedge clk);
        check({tag, "_idle"}, {ready, done, mem_read, mem_write}, 4'b1000);
        check({tag, "_hold"}, snapshot, v.exp_snap);
    endtask

    task automatic abort_vec(input logic [1:0] o, input logic [24:0] line, input int idx,
                             input bit in_write, input string tag);
        int cyc;
        bit found;
        logic [24:0] mask;
        cyc = 0;
        found = 1'b0;
        mask = '0;
        for (int i = 0; i < idx; i++) mask[MS-1-i] = 1'b1;
        @(negedge clk);
        start = 1'b1;
        op = o;
        line_in = line;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (!found && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if ((in_write ? mem_write : mem_read) && int'(mem_index) == idx) found = 1'b1;
        end
        check({tag, "_found"}, 32'(found), 32'd1);
        check({tag, "_cyc"}, cyc, (o == C_COPY) ? 2 + idx : 2 + 2 * idx + int'(in_write));
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check({tag, "_done_ab"}, {done, aborted}, 2'b11);
        check({tag, "_quiet"}, {mem_init, mem_read, mem_write}, 3'b000);
        check({tag, "_mem"}, mem_q, model_mem(o, line, idx + int'(in_write)));
        check({tag, "_snap"}, snapshot & mask, line & mask);
        @(negedge clk);
        check({tag, "_idle"}, {ready, done, aborted}, 3'b100);
    endtask

    initial begin
        int cyc;
        bit got;
        bit found;
        logic [24:0] l1;
        vec_t vx;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        op = 2'b00;
        line_in = '0;
        #12;
        check("rst_ctrl", {ready, done, aborted, mem_init, mem_read, mem_write, mem_val},
              7'b1000000);
        check("rst_snap", snapshot, 0);
        check("rst_line", mem_line, 0);
        check("rst_index", mem_index, 0);
`ifdef PARITY_EN
        check("rst_parity", parity, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", {ready, done}, 2'b10);

        vecs[0] = '{C_COPY, 25'h1555555, 25'h1555555, 25'h1555555, 1'b1, 27};
        vecs[1] = '{C_INV,  25'h0000000, 25'h0000000, 25'h1FFFFFF, 1'b0, 52};
        vecs[2] = '{C_COPY, 25'h0000007, 25'h0000007, 25'h0000007, 1'b1, 27};
        vecs[3] = '{C_COPY, 25'h0000003, 25'h0000003, 25'h0000003, 1'b0, 27};
        vecs[4] = '{C_CLR,  25'h0AAAAAA, 25'h0AAAAAA, 25'h0000000, 1'b0, 52};
        vecs[5] = '{C_SET,  25'h1000001, 25'h1000001, 25'h1FFFFFF, 1'b0, 52};
        for (int i = 6; i < 12; i++) begin
            vecs[i].op = 2'($urandom_range(0, 3));
            vecs[i].line = 25'($urandom);
            vecs[i].exp_snap = vecs[i].line;
            vecs[i].exp_mem = model_mem(vecs[i].op, vecs[i].line, MS);
            vecs[i].exp_par = ^vecs[i].line;
            vecs[i].exp_lat = model_lat(vecs[i].op);
        end
        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);

        // start together with abort in IDLE: the abort is ignored.
        vx = '{C_INV, 25'h0F0F0F0, 25'h0F0F0F0, 25'h10F0F0F, 1'b0, 52};
        run_vec(vx, "start_abort", 1'b1);

        // Back-to-back SET then COPY with start held high throughout.
        l1 = 25'($urandom);
        @(negedge clk);
        start = 1'b1;
        op = C_SET;
        line_in = l1;
        @(posedge clk);
        #1;
        op = C_COPY;
        line_in = 25'h1FFFFFF;
        wait_done(200, cyc, got);
        check("b2b_set_done", 32'(got), 32'd1);
        check("b2b_set_lat", cyc, 52);
        check("b2b_set_inits", n_init, 1);
        check("b2b_set_mem", mem_q, 25'h1FFFFFF);
        check("b2b_set_snap", snapshot, l1);
        @(negedge clk);
        check("b2b_gap", {ready, mem_init}, 2'b10);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(200, cyc, got);
        check("b2b_copy_lat", cyc, 27);
        check("b2b_copy_snap", snapshot, 25'h1FFFFFF);
        check("b2b_copy_writes", n_write, 0);

        // Aborts in READ and in WRITE.
        abort_vec(C_CLR, 25'h1FFFFFF, 10, 1'b0, "ab_clr_r10");
        abort_vec(C_INV, 25'($urandom), 3, 1'b1, "ab_inv_w3");
        abort_vec(C_COPY, 25'($urandom), 7, 1'b0, "ab_copy_r7");
        abort_vec(C_SET, 25'($urandom), int'($urandom_range(0, 24)), 1'b1, "ab_set_rnd");

        // Reset during the WRITE of index 5.
        @(negedge clk);
        start = 1'b1;
        op = C_INV;
        line_in = 25'($urandom);
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        found = 1'b0;
        while (!found && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (mem_write && mem_index == 5'd5) found = 1'b1;
        end
        check("mid_rst_found", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", {ready, done, aborted, mem_init, mem_read, mem_write, mem_val},
              7'b1000000);
        check("mid_rst_snap", snapshot, 0);
        check("mid_rst_line", mem_line, 0);
        check("mid_rst_index", mem_index, 0);
        @(negedge clk);
        rst_n = 1'b1;
        vx.op = C_SET;
        vx.line = 25'($urandom);
        vx.exp_snap = vx.line;
        vx.exp_mem = model_mem(C_SET, vx.line, MS);
        vx.exp_par = ^vx.line;
        vx.exp_lat = model_lat(C_SET);
        run_vec(vx, "post_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
